// File: rtl/rstseq_pkg.sv
// rtl/rstseq_pkg.sv - shared state encoding and synchroniser depth for the reset sequencer
package rstseq_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAULT
  } seqState;

endpackage

// File: rtl/sync2ff.sv
// rtl/sync2ff.sv - parametrised-width multi-flop synchroniser for async level inputs
module sync2ff
  import rstseq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [SYNC_DEPTH-1:0][W-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - debounced, lock-chained DCM reset sequencer with timeout/retry
// Optional lock-loss counter enabled by RSTSEQ_LOSS_CNT_EN.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int STAGES        = 3,
  parameter int DEBOUNCE_W    = 16,
  parameter int SETTLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int MAX_RETRIES   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rstRaw,
  input  logic [STAGES-1:0] locked,
  output logic [STAGES-1:0] stageRst,
  output logic              sysRst,
  output logic              allLocked,
  output logic              fault,
  output logic [3:0]        retries,
  output logic [7:0]        lossCount
);

  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic              btnSync;
  logic [STAGES-1:0] lockSync;

  sync2ff #(.W(1))      uBtnSync  (.clk(clk), .rst(rst), .d(rstRaw), .q(btnSync));
  sync2ff #(.W(STAGES)) uLockSync (.clk(clk), .rst(rst), .d(locked), .q(lockSync));

  seqState           state, stateN;
  logic [IW-1:0]     idx, idxN;
  logic [DEBOUNCE_W-1:0] deb, debN;
  logic [TW-1:0]     timer, timerN;
  logic [SW-1:0]     settleCnt, settleN;
  logic [3:0]        retN;
  logic              faultN;
  logic [STAGES-1:0] stageRstN;
  logic [STAGES-1:0] lowMask;
  logic              lowDrop;

  assign allLocked = &lockSync;
  // A lock drop on any already-released stage below idx aborts the sequence
  assign lowMask   = (STAGES'(1) << idx) - STAGES'(1);
  assign lowDrop   = |(~lockSync & lowMask);

  always_comb begin
    stateN    = state;
    idxN      = idx;
    debN      = deb;
    timerN    = timer;
    settleN   = settleCnt;
    retN      = retries;
    faultN    = fault;
    stageRstN = stageRst;
    if (btnSync) begin
      stateN = HOLD;
      debN   = '0;
      retN   = 4'd0;
      faultN = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (&deb) begin
            stateN = RELEASE;
            idxN   = '0;
          end else begin
            debN = deb + 1'b1;
          end
        end
        RELEASE: begin
          timerN = '0;
          if (lowDrop) begin
            stateN = HOLD;
            debN   = '1;
          end else begin
            stateN = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (lowDrop) begin
            stateN = HOLD;
            debN   = '1;
          end else if (lockSync[idx]) begin
            if (idx == IW'(STAGES - 1)) begin
              stateN  = SETTLE;
              settleN = '0;
            end else begin
              stateN = RELEASE;
              idxN   = idx + 1'b1;
            end
          end else if (timer == TW'(LOCK_TIMEOUT)) begin
            retN = retries + 4'd1;
            if (retN >= 4'(MAX_RETRIES)) begin
              stateN = FAULT;
              faultN = 1'b1;
            end else begin
              stateN = HOLD;
              debN   = '1;
            end
          end else begin
            timerN = timer + 1'b1;
          end
        end
        SETTLE: begin
          if (!allLocked) begin
            stateN = HOLD;
            debN   = '1;
          end else if (settleCnt == SW'(SETTLE_CYCLES - 1)) begin
            stateN = RUN;
          end else begin
            settleN = settleCnt + 1'b1;
          end
        end
        RUN: begin
          retN = 4'd0;
          if (!allLocked) begin
            stateN = HOLD;
            debN   = '1;
          end
        end
        FAULT: begin
          faultN = 1'b1;
        end
        default: begin
          stateN = HOLD;
        end
      endcase
    end
    // Released bits are recomputed from idx so they can only fall in index order
    case (stateN)
      HOLD, FAULT: stageRstN = '1;
      RELEASE:     stageRstN = ~(((STAGES'(1) << idxN) << 1) - STAGES'(1));
      default:     stageRstN = stageRst;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      idx       <= '0;
      deb       <= '0;
      timer     <= '0;
      settleCnt <= '0;
      retries   <= 4'd0;
      fault     <= 1'b0;
      stageRst  <= '1;
      sysRst    <= 1'b1;
    end else begin
      state     <= stateN;
      idx       <= idxN;
      deb       <= debN;
      timer     <= timerN;
      settleCnt <= settleN;
      retries   <= retN;
      fault     <= faultN;
      stageRst  <= stageRstN;
      sysRst    <= (stateN != RUN);
    end
  end

`ifdef RSTSEQ_LOSS_CNT_EN
  logic [7:0] lossQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      lossQ <= 8'd0;
    end else if (state == RUN && !btnSync && !allLocked && lossQ != 8'hFF) begin
      lossQ <= lossQ + 8'd1;
    end
  end

  assign lossCount = lossQ;
`else
  assign lossCount = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench: expected output-change events vs monitored DUT changes
module tb_reset_sequencer;

  localparam int STAGES   = 3;
  localparam int SETTLE   = 8;
  localparam int TIMEOUT  = 32;
  localparam int LOCK_DLY = 5;
`ifdef RSTSEQ_LOSS_CNT_EN
  localparam logic [7:0] L1 = 8'd1;
`else
  localparam logic [7:0] L1 = 8'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rstRaw;
  logic [STAGES-1:0] locked = '0;
  logic [STAGES-1:0] stageRst;
  logic sysRst, allLocked, fault;
  logic [3:0] retries;
  logic [7:0] lossCount;

  reset_sequencer #(
    .STAGES(STAGES), .DEBOUNCE_W(4), .SETTLE_CYCLES(SETTLE),
    .LOCK_TIMEOUT(TIMEOUT), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst(rst), .rstRaw(rstRaw), .locked(locked),
    .stageRst(stageRst), .sysRst(sysRst), .allLocked(allLocked),
    .fault(fault), .retries(retries), .lossCount(lossCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] vec;
    int          dly;
  } expT;

  expT q[$];
  int checks = 0;
  int errors = 0;
  logic monOn = 1'b0;
  logic [STAGES-1:0] en = '1;
  logic [STAGES-1:0] dropMask = '0;

  wire [17:0] vec = {stageRst, sysRst, allLocked, fault, retries, lossCount};

  function automatic logic [17:0] mk(logic [2:0] s, logic sy, logic al, logic f,
                                     logic [3:0] r, logic [7:0] l);
    return {s, sy, al, f, r, l};
  endfunction

  task automatic push(string n, logic [17:0] v, int d);
    q.push_back('{n, v, d});
  endtask

  task automatic drain(string n);
    int k = 0;
    while (q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d pending want 0", n, q.size());
      q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  // DCM model: lock rises LOCK_DLY cycles after stageRst falls, gated by en/dropMask
  initial begin
    int cnt[STAGES];
    for (int j = 0; j < STAGES; j++) cnt[j] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int j = 0; j < STAGES; j++) begin
        if (stageRst[j] !== 1'b0) cnt[j] = 0;
        else if (cnt[j] < 100) cnt[j] = cnt[j] + 1;
        locked[j] = (cnt[j] > LOCK_DLY) && en[j] && !dropMask[j];
      end
    end
  end

  // Monitor: every change of the output vector consumes one expected event
  initial begin
    logic [17:0] prev;
    int cyc;
    expT e;
    prev = '0;
    cyc  = 0;
    forever begin
      @(negedge clk);
      if (!monOn) begin
        prev = vec;
        cyc  = 0;
      end else begin
        cyc++;
        if (vec !== prev) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change got %h want %h", vec, prev);
          end else begin
            e = q.pop_front();
            if (vec !== e.vec || (e.dly >= 0 && cyc != e.dly)) begin
              errors++;
              $display("FAIL %s got %h dly %0d want %h dly %0d", e.name, vec, cyc, e.vec, e.dly);
            end
          end
          prev = vec;
          cyc  = 0;
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    rstRaw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (vec !== mk(3'b111, 1, 0, 0, 4'd0, 8'd0)) begin
      errors++;
      $display("FAIL reset_state got %h want %h", vec, mk(3'b111, 1, 0, 0, 4'd0, 8'd0));
    end
    monOn = 1'b1;

    // Power-up sequence; sysRst falls one transition cycle plus SETTLE cycles after allLocked
    push("t1_s0", mk(3'b110, 1, 0, 0, 4'd0, 8'd0), -1);
    push("t1_s1", mk(3'b100, 1, 0, 0, 4'd0, 8'd0), LOCK_DLY + 3);
    push("t1_s2", mk(3'b000, 1, 0, 0, 4'd0, 8'd0), LOCK_DLY + 3);
    push("t1_all", mk(3'b000, 1, 1, 0, 4'd0, 8'd0), LOCK_DLY + 2);
    push("t1_run", mk(3'b000, 0, 1, 0, 4'd0, 8'd0), SETTLE + 1);
    rst = 1'b0;
    drain("t1");

    // One-cycle lock loss on stage 0 while running
    push("t4_drop", mk(3'b000, 0, 0, 0, 4'd0, 8'd0), -1);
    push("t4_hold", mk(3'b111, 1, 1, 0, 4'd0, L1), 1);
    push("t4_s0", mk(3'b110, 1, 1, 0, 4'd0, L1), 1);
    push("t4_unlk", mk(3'b110, 1, 0, 0, 4'd0, L1), 1);
    push("t4_s1", mk(3'b100, 1, 0, 0, 4'd0, L1), -1);
    push("t4_s2", mk(3'b000, 1, 0, 0, 4'd0, L1), LOCK_DLY + 3);
    push("t4_all", mk(3'b000, 1, 1, 0, 4'd0, L1), LOCK_DLY + 2);
    push("t4_run", mk(3'b000, 0, 1, 0, 4'd0, L1), SETTLE + 1);
    @(negedge clk) dropMask[0] = 1'b1;
    @(negedge clk) dropMask[0] = 1'b0;
    drain("t4");

    // Bouncing button: 3 cycles pressed every 10 must keep the sequencer in HOLD
    push("t2_press", mk(3'b111, 1, 1, 0, 4'd0, L1), -1);
    push("t2_unlk", mk(3'b111, 1, 0, 0, 4'd0, L1), 2);
    for (int p = 0; p < 6; p++) begin
      @(negedge clk) rstRaw = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk) rstRaw = 1'b0;
      repeat (6) @(negedge clk);
    end
    rstRaw = 1'b1;
    drain("t2");

    // Stage 1 never locks: one retry, then FAULT
    en[1] = 1'b0;
    push("t3_s0", mk(3'b110, 1, 0, 0, 4'd0, L1), -1);
    push("t3_s1", mk(3'b100, 1, 0, 0, 4'd0, L1), LOCK_DLY + 3);
    push("t3_to1", mk(3'b111, 1, 0, 0, 4'd1, L1), TIMEOUT + 2);
    push("t3_r_s0", mk(3'b110, 1, 0, 0, 4'd1, L1), 1);
    push("t3_r_s1", mk(3'b100, 1, 0, 0, 4'd1, L1), LOCK_DLY + 3);
    push("t3_fault", mk(3'b111, 1, 0, 1, 4'd2, L1), TIMEOUT + 2);
    rstRaw = 1'b0;
    drain("t3");

    // Button press clears FAULT; quiet release restarts the full sequence
    push("t5_clr", mk(3'b111, 1, 0, 0, 4'd0, L1), -1);
    rstRaw = 1'b1;
    repeat (5) @(negedge clk);
    drain("t5a");
    en[1] = 1'b1;
    push("t5_s0", mk(3'b110, 1, 0, 0, 4'd0, L1), -1);
    push("t5_s1", mk(3'b100, 1, 0, 0, 4'd0, L1), LOCK_DLY + 3);
    push("t5_s2", mk(3'b000, 1, 0, 0, 4'd0, L1), LOCK_DLY + 3);
    push("t5_all", mk(3'b000, 1, 1, 0, 4'd0, L1), LOCK_DLY + 2);
    push("t5_run", mk(3'b000, 0, 1, 0, 4'd0, L1), SETTLE + 1);
    rstRaw = 1'b0;
    drain("t5b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
